// File: rtl/cpu_interrupt_handler.sv
// cpu_interrupt_handler
//   Runs the post-instruction interrupt sequence of a 6502-style CPU: BRK and
//   NMI pushes with vector fetch, RTI pulls, soft-reset vector fetch, or a plain
//   pass-through of the CPU state. The handler owns the memory bus while busy.
//
// Build option:
//   CPU_IH_NMI_EN  defined   -> NMI raised on a rising edge of ppu_status[7]
//                  undefined -> ppu_status ignored, NMI never pending
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   halt                     freezes all state, forces write_en low
//   interrupt_start          one-cycle request, accepted when not busy
//   is_break, is_rti         current instruction is BRK / RTI
//   soft_reset               soft reset request (latched until serviced)
//   ppu_status[7:0]          bit 7 = vblank NMI line
//   pc_next/ie_status/stack_ptr  CPU state at the request
//   mem_data_in[7:0]         memory read data
//   interrupt_addr/_data_out/_write_en  memory bus
//   interrupt_busy/_done     sequence in progress / finished
//   interrupt_pc_out/_status_out/_stack_out  resulting CPU state
//   interrupt_disable        status bit 2 (I flag)
module cpu_interrupt_handler (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        interrupt_start,
  input  logic        is_break,
  input  logic        is_rti,
  input  logic        soft_reset,
  input  logic [7:0]  ppu_status,
  input  logic [15:0] pc_next,
  input  logic [7:0]  ie_status,
  input  logic [7:0]  stack_ptr,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] interrupt_addr,
  output logic [7:0]  interrupt_data_out,
  output logic        interrupt_write_en,
  output logic        interrupt_busy,
  output logic        interrupt_done,
  output logic [15:0] interrupt_pc_out,
  output logic [7:0]  interrupt_status_out,
  output logic [7:0]  interrupt_stack_out,
  output logic        interrupt_disable
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Routine run inside ST_SEQ
  localparam logic [2:0] R_PASS = 3'd0;
  localparam logic [2:0] R_BRK  = 3'd1;
  localparam logic [2:0] R_NMI  = 3'd2;
  localparam logic [2:0] R_RTI  = 3'd3;
  localparam logic [2:0] R_SRST = 3'd4;

  logic [1:0]  state_q, state_d;
  logic [2:0]  rout_q, rout_d;
  logic [2:0]  step_q, step_d;
  logic [1:0]  sub_q, sub_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  st_q, st_d;
  logic [7:0]  sp_q, sp_d;
  logic        srst_pend_q, srst_pend_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        nmi_edge;

  // Micro-op decode of the current step
  logic        op_push, op_read, op_pull, op_last;
  logic        ld_pcl, ld_pch, ld_st, set_i;
  logic [15:0] rd_addr, vec_base;
  logic [7:0]  push_data, sp_inc;
  logic        step_done;

`ifdef CPU_IH_NMI_EN
  logic ppu_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ppu_prev_q <= 1'b0;
    end else if (!halt) begin
      ppu_prev_q <= ppu_status[7];
    end
  end

  assign nmi_edge = ppu_status[7] & ~ppu_prev_q;
`else
  assign nmi_edge = 1'b0;
`endif

  // Only bit 7 of the PPU status carries meaning here
  logic unused_ppu;
  assign unused_ppu = ^ppu_status;

  assign sp_inc = sp_q + 8'd1;

  always_comb begin
    case (rout_q)
      R_BRK:   vec_base = 16'hFFFE;
      R_NMI:   vec_base = 16'hFFFA;
      R_SRST:  vec_base = 16'hFFFC;
      default: vec_base = 16'h0000;
    endcase
  end

  always_comb begin
    op_push   = 1'b0;
    op_read   = 1'b0;
    op_pull   = 1'b0;
    op_last   = 1'b0;
    ld_pcl    = 1'b0;
    ld_pch    = 1'b0;
    ld_st     = 1'b0;
    set_i     = 1'b0;
    rd_addr   = '0;
    push_data = '0;
    if (state_q == ST_SEQ) begin
      case (rout_q)
        R_BRK, R_NMI: begin
          case (step_q)
            3'd0: begin
              op_push   = 1'b1;
              push_data = pc_q[15:8];
            end
            3'd1: begin
              op_push   = 1'b1;
              push_data = pc_q[7:0];
            end
            3'd2: begin
              op_push   = 1'b1;
              set_i     = 1'b1;
              // BRK pushes B=1; NMI pushes B=0. Bit 5 is always set.
              push_data = (rout_q == R_BRK) ? (st_q | 8'h30)
                                            : ((st_q | 8'h20) & 8'hEF);
            end
            3'd3: begin
              op_read = 1'b1;
              rd_addr = vec_base;
              ld_pcl  = 1'b1;
            end
            default: begin
              op_read = 1'b1;
              rd_addr = vec_base + 16'd1;
              ld_pch  = 1'b1;
              op_last = 1'b1;
            end
          endcase
        end
        R_RTI: begin
          // Pull address uses sp+1 throughout; sp itself moves when the byte lands
          op_pull = 1'b1;
          rd_addr = {8'h01, sp_inc};
          case (step_q)
            3'd0:    ld_st  = 1'b1;
            3'd1:    ld_pcl = 1'b1;
            default: begin
              ld_pch  = 1'b1;
              op_last = 1'b1;
            end
          endcase
        end
        R_SRST: begin
          op_read = 1'b1;
          if (step_q == 3'd0) begin
            rd_addr = vec_base;
            ld_pcl  = 1'b1;
          end else begin
            rd_addr = vec_base + 16'd1;
            ld_pch  = 1'b1;
            op_last = 1'b1;
          end
        end
        default: op_last = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    rout_d      = rout_q;
    step_d      = step_q;
    sub_d       = sub_q;
    pc_d        = pc_q;
    st_d        = st_q;
    sp_d        = sp_q;
    srst_pend_d = srst_pend_q | soft_reset;
    nmi_pend_d  = nmi_pend_q | nmi_edge;
    step_done   = 1'b0;
    case (state_q)
      ST_SEQ: begin
        if (op_push) begin
          sp_d      = sp_q - 8'd1;
          step_done = 1'b1;
          if (set_i) begin
            st_d = st_q | 8'h04;
          end
          // A fresh edge arriving in the same cycle stays pending
          if ((rout_q == R_NMI) && (step_q == 3'd0)) begin
            nmi_pend_d = nmi_edge;
          end
        end else if (op_read || op_pull) begin
          // Address is held for sub-cycles 0..1; data is sampled at the end of 2
          if (sub_q == 2'd2) begin
            sub_d     = '0;
            step_done = 1'b1;
            if (op_pull) sp_d = sp_inc;
            if (ld_st)   st_d = mem_data_in & 8'hCF;
            if (ld_pcl)  pc_d[7:0] = mem_data_in;
            if (ld_pch)  pc_d[15:8] = mem_data_in;
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end else begin
          step_done = 1'b1;
        end
        if (step_done) begin
          if (!op_last) begin
            step_d = step_q + 3'd1;
          end else if ((rout_q != R_NMI) && nmi_pend_q) begin
            // Pending NMI runs on the state left by the first routine
            rout_d = R_NMI;
            step_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        if (interrupt_start) begin
          state_d = ST_SEQ;
          step_d  = '0;
          sub_d   = '0;
          pc_d    = pc_next;
          st_d    = ie_status;
          sp_d    = stack_ptr;
          if (srst_pend_q || soft_reset) begin
            rout_d      = R_SRST;
            sp_d        = stack_ptr - 8'd3;
            st_d        = ie_status | 8'h04;
            srst_pend_d = 1'b0;
          end else if (is_rti) begin
            rout_d = R_RTI;
          end else if (is_break) begin
            rout_d = R_BRK;
          end else begin
            rout_d = R_PASS;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rout_q      <= R_PASS;
      step_q      <= '0;
      sub_q       <= '0;
      pc_q        <= '0;
      st_q        <= 8'h04;
      sp_q        <= 8'hFD;
      srst_pend_q <= 1'b0;
      nmi_pend_q  <= 1'b0;
    end else if (!halt) begin
      state_q     <= state_d;
      rout_q      <= rout_d;
      step_q      <= step_d;
      sub_q       <= sub_d;
      pc_q        <= pc_d;
      st_q        <= st_d;
      sp_q        <= sp_d;
      srst_pend_q <= srst_pend_d;
      nmi_pend_q  <= nmi_pend_d;
    end
  end

  assign interrupt_addr       = op_push ? {8'h01, sp_q}
                                        : ((op_read || op_pull) ? rd_addr : 16'h0000);
  assign interrupt_data_out   = op_push ? push_data : 8'h00;
  assign interrupt_write_en   = op_push & ~halt;
  assign interrupt_busy       = (state_q == ST_SEQ);
  assign interrupt_done       = (state_q == ST_DONE);
  assign interrupt_pc_out     = pc_q;
  assign interrupt_status_out = st_q;
  assign interrupt_stack_out  = sp_q;
  assign interrupt_disable    = st_q[2];

endmodule

// File: tb/tb_cpu_interrupt_handler.sv
// Self-checking bench for cpu_interrupt_handler: directed scenarios plus
// randomized transactions compared against a transaction-level 6502 model.
module tb_cpu_interrupt_handler;

  logic        clk = 1'b0;
  logic        rst, halt, interrupt_start, is_break, is_rti, soft_reset;
  logic [7:0]  ppu_status, ie_status, stack_ptr, mem_data_in;
  logic [15:0] pc_next;
  logic [15:0] interrupt_addr;
  logic [7:0]  interrupt_data_out;
  logic        interrupt_write_en, interrupt_busy, interrupt_done;
  logic [15:0] interrupt_pc_out;
  logic [7:0]  interrupt_status_out, interrupt_stack_out;
  logic        interrupt_disable;

  localparam int K_PASS = 0;
  localparam int K_BRK  = 1;
  localparam int K_RTI  = 2;
  localparam int K_SRST = 3;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mem [0:65535];
  logic [23:0] wr_log[$];
  logic        pk_en;
  logic [15:0] pk_addr;
  logic [7:0]  pk_data;

  // Model state
  logic [23:0] exp_wr[$];
  logic [15:0] m_pc;
  logic [7:0]  m_st, m_sp;
  int          m_cyc;

  cpu_interrupt_handler dut (
    .clk                  (clk),
    .rst                  (rst),
    .halt                 (halt),
    .interrupt_start      (interrupt_start),
    .is_break             (is_break),
    .is_rti               (is_rti),
    .soft_reset           (soft_reset),
    .ppu_status           (ppu_status),
    .pc_next              (pc_next),
    .ie_status            (ie_status),
    .stack_ptr            (stack_ptr),
    .mem_data_in          (mem_data_in),
    .interrupt_addr       (interrupt_addr),
    .interrupt_data_out   (interrupt_data_out),
    .interrupt_write_en   (interrupt_write_en),
    .interrupt_busy       (interrupt_busy),
    .interrupt_done       (interrupt_done),
    .interrupt_pc_out     (interrupt_pc_out),
    .interrupt_status_out (interrupt_status_out),
    .interrupt_stack_out  (interrupt_stack_out),
    .interrupt_disable    (interrupt_disable)
  );

  always #5 clk = ~clk;

  // Memory with one-cycle registered read; sole writer of mem and wr_log
  always @(posedge clk) begin
    if (interrupt_write_en) begin
      mem[interrupt_addr] <= interrupt_data_out;
      wr_log.push_back({interrupt_addr, interrupt_data_out});
    end else if (pk_en) begin
      mem[pk_addr] <= pk_data;
    end
    mem_data_in <= mem[interrupt_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic m_push(input logic [7:0] d);
    exp_wr.push_back({8'h01, m_sp, d});
    m_sp  = m_sp - 8'd1;
    m_cyc = m_cyc + 1;
  endtask

  task automatic m_pull(output logic [7:0] d);
    m_sp  = m_sp + 8'd1;
    d     = mem[{8'h01, m_sp}];
    m_cyc = m_cyc + 3;
  endtask

  task automatic m_vec(input logic [15:0] lo_addr);
    m_pc  = {mem[lo_addr + 16'd1], mem[lo_addr]};
    m_cyc = m_cyc + 6;
  endtask

  // 6502 semantics at transaction level: expected writes, final state, latency
  task automatic model(input int kind, input bit nmi, input logic [15:0] pc,
                       input logic [7:0] st, input logic [7:0] sp);
    logic [7:0] b;
    exp_wr.delete();
    m_pc = pc; m_st = st; m_sp = sp; m_cyc = 1;
    case (kind)
      K_SRST: begin
        m_sp = m_sp - 8'd3;
        m_st = m_st | 8'h04;
        m_vec(16'hFFFC);
      end
      K_RTI: begin
        m_pull(b); m_st = b & 8'hCF;
        m_pull(b); m_pc[7:0] = b;
        m_pull(b); m_pc[15:8] = b;
      end
      K_BRK: begin
        m_push(m_pc[15:8]);
        m_push(m_pc[7:0]);
        m_push(m_st | 8'h30);
        m_st = m_st | 8'h04;
        m_vec(16'hFFFE);
      end
      default: m_cyc = m_cyc + 1;
    endcase
    if (nmi) begin
      m_push(m_pc[15:8]);
      m_push(m_pc[7:0]);
      m_push((m_st | 8'h20) & 8'hEF);
      m_st = m_st | 8'h04;
      m_vec(16'hFFFA);
    end
  endtask

  task automatic run_txn(input string tag, input bit srst, input bit rti, input bit brk,
                         input bit nmi, input logic [15:0] pc, input logic [7:0] st,
                         input logic [7:0] sp, input int halt_at);
    int kind, cyc, base, wc, nw;
    bit nmi_eff;
    if (srst) begin
      soft_reset = 1'b1;
      @(negedge clk);
      soft_reset = 1'b0;
    end
    if (nmi) begin
      ppu_status = {1'b1, 7'($urandom)};
      @(negedge clk);
      ppu_status = {1'b0, 7'($urandom)};
      @(negedge clk);
    end
    kind = srst ? K_SRST : (rti ? K_RTI : (brk ? K_BRK : K_PASS));
`ifdef CPU_IH_NMI_EN
    nmi_eff = nmi;
`else
    nmi_eff = 1'b0;
`endif
    model(kind, nmi_eff, pc, st, sp);
    base = wr_log.size();
    is_break = brk; is_rti = rti; pc_next = pc; ie_status = st; stack_ptr = sp;
    interrupt_start = 1'b1;
    @(negedge clk);
    interrupt_start = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, interrupt_busy, 1'b1);
    chk({tag, "_done_low"}, interrupt_done, 1'b0);
    while (interrupt_done !== 1'b1 && cyc < 200) begin
      if (cyc == halt_at) begin
        halt = 1'b1;
        wc = wr_log.size();
        repeat (5) begin
          @(negedge clk);
          chk({tag, "_halt_we"}, interrupt_write_en, 1'b0);
        end
        chk({tag, "_halt_nowr"}, wr_log.size(), wc);
        chk({tag, "_halt_busy"}, interrupt_busy, 1'b1);
        halt = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, interrupt_done, 1'b1);
    chk({tag, "_busy_end"}, interrupt_busy, 1'b0);
    if (halt_at < 1 && !(kind == K_PASS && nmi_eff)) chk({tag, "_latency"}, cyc, m_cyc);
    nw = wr_log.size() - base;
    chk({tag, "_nwr"}, nw, exp_wr.size());
    for (int i = 0; i < nw && i < exp_wr.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wr_log[base + i], exp_wr[i]);
    chk({tag, "_pc"}, interrupt_pc_out, m_pc);
    chk({tag, "_st"}, interrupt_status_out, m_st);
    chk({tag, "_sp"}, interrupt_stack_out, m_sp);
    chk({tag, "_dis"}, interrupt_disable, m_st[2]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, halt_at;
    logic [7:0] rsp;
    bit r_srst, r_rti, r_brk, r_nmi;
    rst = 1'b0; halt = 1'b0; interrupt_start = 1'b0; is_break = 1'b0; is_rti = 1'b0;
    soft_reset = 1'b0; ppu_status = 8'h00; pc_next = '0; ie_status = '0; stack_ptr = '0;
    pk_en = 1'b0; pk_addr = '0; pk_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", interrupt_busy, 1'b0);
    chk("rst_done", interrupt_done, 1'b0);
    chk("rst_we", interrupt_write_en, 1'b0);
    chk("rst_addr", interrupt_addr, 16'h0000);
    chk("rst_data", interrupt_data_out, 8'h00);
    chk("rst_pc", interrupt_pc_out, 16'h0000);
    chk("rst_st", interrupt_status_out, 8'h04);
    chk("rst_sp", interrupt_stack_out, 8'hFD);
    chk("rst_dis", interrupt_disable, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    // BRK with known vector
    poke(16'hFFFE, 8'h34); poke(16'hFFFF, 8'h12);
    base = wr_log.size();
    run_txn("brk", 0, 0, 1, 0, 16'h8002, 8'h00, 8'hFF, -1);
    chk("brk_lit_pc", interrupt_pc_out, 16'h1234);
    chk("brk_lit_st", interrupt_status_out, 8'h04);
    chk("brk_lit_sp", interrupt_stack_out, 8'hFC);
    if (wr_log.size() == base + 3) begin
      chk("brk_lit_w0", wr_log[base], 24'h01FF80);
      chk("brk_lit_w1", wr_log[base + 1], 24'h01FE02);
      chk("brk_lit_w2", wr_log[base + 2], 24'h01FD30);
    end

    // RTI
    poke(16'h01FD, 8'h31); poke(16'h01FE, 8'h02); poke(16'h01FF, 8'h80);
    run_txn("rti", 0, 1, 0, 0, 16'h5555, 8'hFF, 8'hFC, -1);
    chk("rti_lit_pc", interrupt_pc_out, 16'h8002);
    chk("rti_lit_st", interrupt_status_out, 8'h01);
    chk("rti_lit_sp", interrupt_stack_out, 8'hFF);

    // Pass-through
    run_txn("pass", 0, 0, 0, 0, 16'hC000, 8'h24, 8'hF0, -1);
    chk("pass_lit_pc", interrupt_pc_out, 16'hC000);
    chk("pass_lit_st", interrupt_status_out, 8'h24);
    chk("pass_lit_sp", interrupt_stack_out, 8'hF0);

    // NMI edge, then a plain start
    poke(16'hFFFA, 8'h00); poke(16'hFFFB, 8'hA0);
    base = wr_log.size();
    run_txn("nmi", 0, 0, 0, 1, 16'h9000, 8'h01, 8'hFF, -1);
`ifdef CPU_IH_NMI_EN
    chk("nmi_lit_pc", interrupt_pc_out, 16'hA000);
    chk("nmi_lit_dis", interrupt_disable, 1'b1);
    if (wr_log.size() == base + 3) chk("nmi_lit_w2", wr_log[base + 2], 24'h01FD21);
`else
    chk("nmi_off_pc", interrupt_pc_out, 16'h9000);
    chk("nmi_off_nwr", wr_log.size(), base);
`endif

    // Soft reset
    poke(16'hFFFC, 8'h00); poke(16'hFFFD, 8'h80);
    base = wr_log.size();
    run_txn("srst", 1, 1, 1, 0, 16'h1111, 8'h00, 8'hFF, -1);
    chk("srst_lit_pc", interrupt_pc_out, 16'h8000);
    chk("srst_lit_sp", interrupt_stack_out, 8'hFC);
    chk("srst_lit_nwr", wr_log.size(), base);

    // Halt for 5 cycles in the middle of BRK pushes
    run_txn("halt", 0, 0, 1, 0, 16'h8002, 8'h00, 8'hFF, 2);
    chk("halt_lit_pc", interrupt_pc_out, 16'h1234);
    chk("halt_lit_sp", interrupt_stack_out, 8'hFC);

    // Stack pointer wrap in both directions
    run_txn("brk_wrap", 0, 0, 1, 0, 16'hBEEF, 8'hC3, 8'h01, -1);
    poke(16'h01FF, 8'h7E); poke(16'h0100, 8'h44); poke(16'h0101, 8'h9A);
    run_txn("rti_wrap", 0, 1, 0, 0, 16'h0000, 8'h00, 8'hFE, -1);

    // Reset in the middle of a BRK: aborts at once, no further writes
    base = wr_log.size();
    is_break = 1'b1; is_rti = 1'b0; pc_next = 16'h4321; ie_status = 8'h00; stack_ptr = 8'h80;
    interrupt_start = 1'b1;
    @(negedge clk);
    interrupt_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", interrupt_busy, 1'b0);
    chk("abort_we", interrupt_write_en, 1'b0);
    chk("abort_addr", interrupt_addr, 16'h0000);
    chk("abort_st", interrupt_status_out, 8'h04);
    chk("abort_sp", interrupt_stack_out, 8'hFD);
    repeat (3) @(negedge clk);
    chk("abort_nwr", wr_log.size() - base, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_done", interrupt_done, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      for (int v = 0; v < 6; v++) poke(16'hFFFA + 16'(v), 8'($urandom));
      rsp = 8'($urandom);
      for (int j = 1; j <= 3; j++) poke({8'h01, rsp + 8'(j)}, 8'($urandom));
      r_srst  = ($urandom_range(0, 4) == 0);
      r_rti   = 1'($urandom);
      r_brk   = 1'($urandom);
      r_nmi   = ($urandom_range(0, 2) == 0);
      halt_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : -1;
      run_txn($sformatf("rnd%0d", t), r_srst, r_rti, r_brk, r_nmi,
              16'($urandom), 8'($urandom), rsp, halt_at);
    end

    n = n_checks;
    $display("%0d/%0d checks passed", n_pass, n);
    $finish;
  end

endmodule
